// File: rtl/uart_rx.sv
// uart_rx: oversampling asynchronous serial receiver.
// Mid-bit sampling, start/stop framing checks, valid/ready output.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sig,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
    localparam int CW = $clog2(PULSE_WIDTH) + 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(PULSE_WIDTH - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_PULSE_WIDTH - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    logic                  sync0;
    logic                  line;
    logic [2:0]            state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  stop_ok;
    logic                  stop_bad;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0 <= 1'b1;
            line  <= 1'b1;
        end else begin
            sync0 <= sig;
            line  <= sync0;
        end
    end

    assign stop_ok  = (state == STOP) && (cnt == '0) && line;
    assign stop_bad = (state == STOP) && (cnt == '0) && !line;

    // Frame FSM: half-bit wait to centre on the start bit, then full-bit steps
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!line) begin
                        state <= START;
                        cnt   <= CNT_HALF;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (line) begin
                        state <= IDLE;
                    end else begin
                        state   <= DATA;
                        cnt     <= CNT_FULL;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shift_r[bit_idx] <= line;
                        cnt              <= CNT_FULL;
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= line ? IDLE : BREAK;
                    end
                end
                BREAK: begin
                    if (line) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output holding register with valid/ready handshake and error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= stop_ok && valid && !ready;
            if (stop_ok && (!valid || ready)) begin
                data  <= shift_r;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized checks of uart_rx
// against a behavioural serial transmitter and word queue.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BT = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sig = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    uart_rx #(
        .DATA_WIDTH(8),
        .BAUD_RATE (100_000),
        .CLK_FREQ  (1_000_000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sig      (sig),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    logic [7:0] rxq[$];
    int         n_ferr = 0;
    int         n_ovr = 0;
    int         n_rise = 0;
    int         n_vcyc = 0;
    int         t_rise = 0;
    int         vhigh = 0;
    logic [7:0] rdata = 8'h00;
    logic       pv = 1'b0;
    logic       pacc = 1'b0;
    logic [7:0] pdata = 8'h00;
    bit         rnd = 1'b0;

    // Consumer-side monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (pv && valid && !pacc) check("hold", 32'(data), 32'(pdata));
        if (valid && ready) rxq.push_back(data);
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
        if (valid) n_vcyc++;
        if (valid && !pv) begin
            n_rise++;
            t_rise = cyc;
            rdata  = data;
        end
        vhigh = valid ? vhigh + 1 : 0;
        pv    = valid;
        pacc  = valid && ready;
        pdata = data;
    end

    // Random backpressure that never stalls longer than ~40 cycles
    always @(posedge clk) begin
        #1;
        if (rnd) ready = (vhigh >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_ferr = 0;
        n_ovr  = 0;
        n_rise = 0;
        n_vcyc = 0;
        rxq.delete();
    endtask

    // Transmitter model: start, 8 data bits LSB first, stop level left on line
    task automatic send(input logic [7:0] w, input int bt, input logic stop);
        sig = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            sig = w[i];
            #(bt);
        end
        sig = stop;
        #(bt);
    endtask

    logic [7:0] exp_q[$];
    int         t0;
    int         hits;

    initial begin
        idle(3);
        check("rst_data", 32'(data), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_ovr", 32'(overrun), 0);
        rst = 1'b0;
        idle(20);

        // Single frame, latency from falling edge to valid
        ready = 1'b1;
        clr();
        @(posedge clk);
        #1;
        t0 = cyc;
        send(8'hA5, BT, 1'b1);
        idle(20);
        check("a5_lat", 32'(t_rise - t0), 98);
        check("a5_data", 32'(rdata), 32'hA5);
        check("a5_vcyc", 32'(n_vcyc), 1);
        check("a5_ferr", 32'(n_ferr), 0);
        check("a5_ovr", 32'(n_ovr), 0);

        // Three back-to-back frames while stalled
        ready = 1'b0;
        clr();
        send(8'h00, BT, 1'b1);
        send(8'hFF, BT, 1'b1);
        send(8'h55, BT, 1'b1);
        idle(20);
        check("ovr_data", 32'(data), 32'h00);
        check("ovr_valid", 32'(valid), 1);
        check("ovr_cnt", 32'(n_ovr), 2);
        check("ovr_ferr", 32'(n_ferr), 0);
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
        check("ovr_drain", 32'(valid), 0);
        check("ovr_words", 32'(rxq.size()), 1);

        // Short glitch on the line
        ready = 1'b1;
        clr();
        sig = 1'b0;
        idle(3);
        sig = 1'b1;
        idle(30);
        check("gl_rise", 32'(n_rise), 0);
        check("gl_ferr", 32'(n_ferr), 0);
        send(8'h3C, BT, 1'b1);
        idle(20);
        check("gl_next_n", 32'(n_rise), 1);
        check("gl_next", 32'(rdata), 32'h3C);

        // Bad stop bit followed by a held-low break
        clr();
        send(8'h81, BT, 1'b0);
        #500;
        sig = 1'b1;
        idle(30);
        check("brk_ferr", 32'(n_ferr), 1);
        check("brk_rise", 32'(n_rise), 0);
        send(8'h42, BT, 1'b1);
        idle(20);
        check("brk_next_n", 32'(n_rise), 1);
        check("brk_next", 32'(rdata), 32'h42);
        check("brk_ferr2", 32'(n_ferr), 1);

        // Reset pulse in the middle of data bit 4
        clr();
        fork
            send(8'hC3, BT, 1'b1);
            begin
                #550;
                @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1;
                check("mrst_data", 32'(data), 0);
                check("mrst_valid", 32'(valid), 0);
                check("mrst_ferr", 32'(frame_err), 0);
                check("mrst_ovr", 32'(overrun), 0);
                rst = 1'b0;
            end
        join
        idle(200);
        hits = 0;
        foreach (rxq[i]) if (rxq[i] == 8'hC3) hits++;
        check("mrst_nodeliv", 32'(hits), 0);
        clr();
        send(8'h19, BT, 1'b1);
        idle(20);
        check("mrst_next_n", 32'(n_rise), 1);
        check("mrst_next", 32'(rdata), 32'h19);

        // Random loopback with +-2% bit period and random backpressure
        clr();
        exp_q.delete();
        rnd = 1'b1;
        for (int k = 0; k < 200; k++) begin
            logic [7:0] w;
            w = 8'($urandom);
            exp_q.push_back(w);
            send(w, 98 + int'($urandom_range(0, 4)), 1'b1);
            if ($urandom_range(0, 1) == 1) #($urandom_range(1, 300));
        end
        idle(300);
        rnd = 1'b0;
        check("rnd_count", 32'(rxq.size()), 200);
        for (int i = 0; i < 200; i++) begin
            check("rnd_word",
                  (i < rxq.size()) ? 32'(rxq[i]) : 32'hDEAD,
                  32'(exp_q[i]));
        end
        check("rnd_ovr", 32'(n_ovr), 0);
        check("rnd_ferr", 32'(n_ferr), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Asynchronous serial receiver: the receiving end of the UART link driven by the team's transmitter. It uses the same frame format: 1 start bit (0), DATA_WIDTH data bits LSB-first, 1 stop bit (1), idle high. It oversamples the line on the system clock, samples each bit at mid-bit, and checks start and stop framing. Each received word is presented on a valid/ready output port with overrun and framing-error reporting, for consumption by the command/loopback logic.

Parameters:
DATA_WIDTH, 8, data bits per frame
BAUD_RATE, 115200, line bit rate
CLK_FREQ, 100_000_000, clk frequency in Hz
(derived) PULSE_WIDTH = CLK_FREQ/BAUD_RATE, clocks per bit; HALF_PULSE_WIDTH = PULSE_WIDTH/2; counter width $clog2(PULSE_WIDTH)+1

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
sig  in  1  asynchronous serial line, idle high
data  out  DATA_WIDTH  received word, stable while valid=1
valid  out  1  data holds an unconsumed word
ready  in  1  consumer accepts data on a clk edge where valid&&ready
frame_err  out  1  one-cycle pulse: stop bit sampled 0
overrun  out  1  one-cycle pulse: completed word dropped because the output was still occupied

Behaviour:
- Reset: data=0, valid=0, frame_err=0, overrun=0. Synchronizer flops=1, state=IDLE, counters=0. Reset mid-frame aborts the frame; no partial word is delivered.
- Input: 2-flop synchronizer on sig (reset value 1). All FSM decisions use the synchronized value "line", which adds 2 clk of latency.
- Bit counter cnt: in START/DATA/STOP, if cnt>0 then cnt<=cnt-1; else sample line and reload.
- FSM states IDLE, START, DATA, STOP, BREAK:
  - IDLE: line==0 -> START, cnt<=HALF_PULSE_WIDTH-1.
  - START: at cnt==0, line==1 -> IDLE (glitch rejected, no error pulse). line==0 -> DATA, cnt<=PULSE_WIDTH-1, bit_idx<=0.
  - DATA: at cnt==0, shift_r[bit_idx]<=line, cnt<=PULSE_WIDTH-1. bit_idx==DATA_WIDTH-1 -> STOP; else bit_idx++.
  - STOP: at cnt==0, line==1 -> deliver (below), then IDLE. line==0 -> frame_err=1 for one cycle, word discarded, then BREAK.
  - BREAK: wait for line==1, then IDLE. A held-low line (break) yields exactly one frame_err and no retriggering.
- Deliver, on the clk edge after the stop sample:
  - valid==0, or valid&&ready this cycle: data<=shift_r, valid<=1.
  - valid&&!ready: overrun=1 for one cycle; new word dropped; old data/valid unchanged.
- Handshake: valid stays high until a clk edge with ready=1, then clears (unless a delivery happens in that same cycle, which reloads data and keeps valid=1). ready is ignored while valid=0. data must not change while valid=1 except on an accepting edge.
- Sample points: for a start falling edge detected at cycle T0 (first IDLE cycle with line==0):
  - start bit sampled at T0+HALF_PULSE_WIDTH
  - data bit i sampled at T0+HALF_PULSE_WIDTH+(i+1)*PULSE_WIDTH
  - stop bit sampled at T0+HALF_PULSE_WIDTH+(DATA_WIDTH+1)*PULSE_WIDTH
- Back-to-back frames: the next start edge is accepted from the first IDLE cycle after STOP. The rx must receive the transmitter's minimum spacing with no loss.
- Tolerance: correct reception with the sender's bit period off by up to ±2%.

Test Plan:
- Use CLK_FREQ=1_000_000, BAUD_RATE=100_000 (PULSE_WIDTH=10, HALF=5) unless stated.
- Single frame 0xA5, ready=1: valid pulses 1 cycle, data=0xA5, exactly 2+5+9*10+1 cycles after sig falls. frame_err=0, overrun=0.
- Frames 0x00, 0xFF, 0x55 back-to-back, ready held 0 until after the third stop bit: data=0x00 retained, valid=1, overrun pulses twice, frame_err=0. After a ready pulse, valid=0.
- Glitch: sig low for 3 clk, then high -> no valid, no frame_err; FSM back in IDLE. A following 0x3C frame is received correctly.
- Stop bit forced 0 on frame 0x81, then line held low 50 clk, then high: exactly one frame_err pulse, valid stays 0. A next frame 0x42 is received correctly.
- rst asserted for 1 cycle mid data bit 4 of frame 0xC3: all outputs 0, no delivery. A following frame 0x19 is received as 0x19.
- Random 200 frames, loopback from the team's transmitter (DATA_WIDTH=8, same params), random ready backpressure with the consumer always accepting within 1 frame time: all words match in order, no overrun or frame_err.
